// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - arbitrates I-cache fills, D-cache fills and D-cache write-throughs onto one memory port
//
// Purpose:
//   Serialises three requesters onto a single-word memory port. A fill moves
//   one 16-byte block as 8 word reads. Each read takes one issue cycle and
//   then waits for mem_data_valid. A write-through takes a single cycle.
//   Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, i_req and
//   d_req alternate when both are pending. The default is fixed priority
//   d_wr_req > d_req > i_req.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_req, i_addr                     I-cache fill request / miss address
//   d_req, d_addr                     D-cache fill request / miss address
//   d_wr_req, d_wr_addr, d_wr_data    D-cache write-through request
//   mem_en, mem_wr, mem_addr,
//   mem_data_in, mem_data_valid       memory port
//   i_grant, d_grant                  current owner of the memory port
//   i_data_valid, d_data_valid        mem_data_valid routed to the owner
//   fill_word                         index of the word being filled
//   i_done, d_done                    one-cycle completion pulses
//   busy                              a transaction is in progress

module cache_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    output logic        i_grant,
    output logic        d_grant,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic [2:0]  fill_word,
    output logic        i_done,
    output logic        d_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        I_ISSUE,
        I_WAIT,
        D_ISSUE,
        D_WAIT,
        D_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [11:0] base_q, base_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic        pick_d;
    logic [15:0] fill_addr;

    // The block base is 16-byte aligned, so word k is placed in the low bits without an adder.
    assign fill_addr = {base_q, k_q, 1'b0};

`ifdef ARB_ROUND_ROBIN_EN
    // Records the last fill requester that was served: 0 = I, 1 = D.
    logic last_d_q, last_d_d;

    // When both fills are pending, the requester that was not served last wins.
    assign pick_d = d_req && (!i_req || !last_d_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= 3'd0;
            base_q   <= 12'd0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            base_q   <= base_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        base_d       = base_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d     = last_d_q;
`endif
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_in  = 16'h0000;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        fill_word    = 3'd0;

        case (state_q)
            IDLE: begin
                // Also runs in the cycle that carries a done pulse.
                // A request that is still high at that point is granted again.
                if (d_wr_req) begin
                    state_d = D_WRITE;
                end else if (pick_d) begin
                    state_d = D_ISSUE;
                    base_d  = d_addr[15:4];
                    k_d     = 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_req) begin
                    state_d = I_ISSUE;
                    base_d  = i_addr[15:4];
                    k_d     = 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                end
            end

            I_ISSUE: begin
                i_grant   = 1'b1;
                mem_en    = 1'b1;
                mem_addr  = fill_addr;
                fill_word = k_q;
                state_d   = I_WAIT;
            end

            I_WAIT: begin
                i_grant      = 1'b1;
                mem_addr     = fill_addr;
                fill_word    = k_q;
                i_data_valid = mem_data_valid;
                if (mem_data_valid) begin
                    if (k_q == 3'd7) begin
                        k_d      = 3'd0;
                        i_done_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = I_ISSUE;
                    end
                end
            end

            D_ISSUE: begin
                d_grant   = 1'b1;
                mem_en    = 1'b1;
                mem_addr  = fill_addr;
                fill_word = k_q;
                state_d   = D_WAIT;
            end

            D_WAIT: begin
                d_grant      = 1'b1;
                mem_addr     = fill_addr;
                fill_word    = k_q;
                d_data_valid = mem_data_valid;
                if (mem_data_valid) begin
                    if (k_q == 3'd7) begin
                        k_d      = 3'd0;
                        d_done_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = D_ISSUE;
                    end
                end
            end

            D_WRITE: begin
                d_grant     = 1'b1;
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_data_in = d_wr_data;
                d_done_d    = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
                k_d     = 3'd0;
            end
        endcase
    end

    assign i_done = i_done_q;
    assign d_done = d_done_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter

module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_data_valid;
    logic        i_grant, d_grant, i_data_valid, d_data_valid;
    logic [2:0]  fill_word;
    logic        i_done, d_done, busy;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_valid(mem_data_valid),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .fill_word(fill_word), .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        ig;
        logic        dg;
    } acc_t;

    typedef struct {
        int          kind;    // 0 = I fill, 1 = D fill, 2 = D write
        logic [15:0] addr;
        logic [15:0] wdata;
        int          exp_lat; // clock edges from request to visible done
        int          exp_idv;
        int          exp_ddv;
    } vec_t;

    acc_t exp_q[$];
    vec_t vecs[6];

    int total = 0;
    int passed = 0;
    int i_dv_cnt = 0, d_dv_cnt = 0, i_done_cnt = 0, d_done_cnt = 0;

    // Memory model: returns a word 4 cycles after each read issue, counting the issue cycle.
    logic resp_valid = 1'b0;
    logic spur = 1'b0;
    logic mem_auto = 1'b1;
    int   mem_cnt = 0;
    assign mem_data_valid = resp_valid | spur;

    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (rst || !mem_auto) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) resp_valid = 1'b1;
            end
            if (mem_en && !mem_wr) mem_cnt = 3;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every memory access must match the next expected access.
    always @(negedge clk) begin
        #1;
        if (i_data_valid) i_dv_cnt++;
        if (d_data_valid) d_dv_cnt++;
        if (i_done) i_done_cnt++;
        if (d_done) d_done_cnt++;
        if (mem_en) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_access: got wr=%b addr=%h data=%h expected no access",
                         mem_wr, mem_addr, mem_data_in);
            end else begin
                acc_t e;
                e = exp_q.pop_front();
                check("mem_access", {31'd0, mem_wr, mem_addr, mem_data_in, i_grant, d_grant}, {31'd0, e});
            end
        end
    end

    function automatic logic [43:0] outs();
        return {mem_en, mem_wr, mem_addr, mem_data_in, i_grant, d_grant,
                i_data_valid, d_data_valid, fill_word, i_done, d_done, busy};
    endfunction

    task automatic push_fill(input int kind, input logic [15:0] addr, input int words);
        logic [15:0] base;
        base = {addr[15:4], 4'h0};
        for (int k = 0; k < words; k++)
            exp_q.push_back({1'b0, base + 16'(k * 2), 16'h0000, kind == 0, kind == 1});
    endtask

    task automatic clear_counts();
        i_dv_cnt = 0; d_dv_cnt = 0; i_done_cnt = 0; d_done_cnt = 0;
    endtask

    task automatic wait_done(input int kind, output int n);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            n++;
            if ((kind == 0) ? i_done : d_done) return;
        end
        total++;
        $display("FAIL done_timeout: got no done after 300 cycles expected done kind %0d", kind);
        n = -1;
    endtask

    initial begin
        int n;
        int all_dropped;

        vecs[0] = '{0, 16'hBEEF, 16'h0000, 33, 8, 0};
        vecs[1] = '{1, 16'h0007, 16'h0000, 33, 0, 8};
        vecs[2] = '{0, 16'hFFF9, 16'h0000, 33, 8, 0};
        vecs[3] = '{2, 16'h1234, 16'hDEAD, 2, 0, 0};
        vecs[4] = '{2, 16'hFFFF, 16'h0001, 2, 0, 0};
        vecs[5] = '{1, 16'hA5A0, 16'h0000, 33, 0, 8};

        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; d_wr_req = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(outs()), 64'd0);
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven single-requester transactions.
        for (int v = 0; v < 6; v++) begin
            clear_counts();
            if (vecs[v].kind == 2)
                exp_q.push_back({1'b1, vecs[v].addr, vecs[v].wdata, 1'b0, 1'b1});
            else
                push_fill(vecs[v].kind, vecs[v].addr, 8);
            case (vecs[v].kind)
                0: begin i_addr = vecs[v].addr; i_req = 1'b1; end
                1: begin d_addr = vecs[v].addr; d_req = 1'b1; end
                default: begin
                    d_wr_addr = vecs[v].addr; d_wr_data = vecs[v].wdata; d_wr_req = 1'b1;
                end
            endcase
            wait_done(vecs[v].kind == 0 ? 0 : 1, n);
            i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
            check($sformatf("latency_%0d", v), 64'(n), 64'(vecs[v].exp_lat));
            @(posedge clk); #1;
            check($sformatf("data_valid_count_%0d", v), {i_dv_cnt, d_dv_cnt},
                  {vecs[v].exp_idv, vecs[v].exp_ddv});
            check($sformatf("done_count_%0d", v), {i_done_cnt, d_done_cnt},
                  {32'(vecs[v].kind == 0), 32'(vecs[v].kind != 0)});
            check($sformatf("idle_after_%0d", v), {63'd0, busy}, 64'd0);
            check($sformatf("queue_drained_%0d", v), 64'(exp_q.size()), 64'd0);
        end

        // All three requesters are raised together; each drops its request when it sees done.
        clear_counts();
        exp_q.push_back({1'b1, 16'h3302, 16'h5A5A, 1'b0, 1'b1});
        push_fill(1, 16'h2200, 8);
        push_fill(0, 16'h0100, 8);
        i_addr = 16'h0100; d_addr = 16'h2200; d_wr_addr = 16'h3302; d_wr_data = 16'h5A5A;
        i_req = 1'b1; d_req = 1'b1; d_wr_req = 1'b1;
        all_dropped = 0;
        for (int c = 0; c < 600 && !all_dropped; c++) begin
            @(posedge clk); #1;
            if (d_done) begin
                if (d_wr_req) d_wr_req = 1'b0;
                else d_req = 1'b0;
            end
            if (i_done) i_req = 1'b0;
            all_dropped = !(i_req || d_req || d_wr_req);
        end
        if (!all_dropped) begin
            total++;
            $display("FAIL priority_timeout: got requests still pending expected all served");
            i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
        end
        @(posedge clk); #1;
        check("priority_order_drained", 64'(exp_q.size()), 64'd0);
        check("priority_done_counts", {i_done_cnt, d_done_cnt}, {32'd1, 32'd2});

        // Reset after the third valid of a D fill aborts it without a done pulse.
        clear_counts();
        push_fill(1, 16'hDEAD, 3);
        d_addr = 16'hDEAD; d_req = 1'b1;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #2;
            if (d_dv_cnt == 3) begin n = 1; break; end
        end
        check("third_valid_seen", 64'(n), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_fill_reset_outputs", 64'(outs()), 64'd0);
        @(posedge clk); #1;
        check("request_during_rst", {63'd0, busy}, 64'd0);
        push_fill(1, 16'hDEA0, 8);
        rst = 1'b0;
        wait_done(1, n);
        d_req = 1'b0;
        check("refill_latency", 64'(n), 64'd33);
        @(posedge clk); #1;
        check("aborted_no_done", 64'(d_done_cnt), 64'd1);
        check("refill_valid_count", 64'(d_dv_cnt), 64'd11);
        check("refill_drained", 64'(exp_q.size()), 64'd0);

        // Stray mem_data_valid in IDLE and in I_ISSUE must be ignored.
        mem_auto = 1'b0;
        spur = 1'b1;
        #1;
        check("idle_spurious_route", {62'd0, i_data_valid, d_data_valid}, 64'd0);
        @(posedge clk); #1;
        spur = 1'b0;
        check("idle_spurious_state", {60'd0, fill_word, busy}, 64'd0);
        push_fill(0, 16'h4447, 2);
        i_addr = 16'h4447; i_req = 1'b1;
        @(posedge clk); #1;
        spur = 1'b1;
        #1;
        check("issue_spurious_route", {63'd0, i_data_valid}, 64'd0);
        @(posedge clk); #1;
        spur = 1'b0;
        i_req = 1'b0;
        check("issue_spurious_word", {60'd0, fill_word, busy}, {60'd0, 3'd0, 1'b1});
        spur = 1'b1;
        #1;
        check("wait_valid_routed", {62'd0, i_data_valid, d_data_valid}, 64'd2);
        @(posedge clk); #1;
        spur = 1'b0;
        check("word_advanced", 64'(fill_word), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_auto = 1'b1;
        @(posedge clk); #1;
        check("spurious_drained", 64'(exp_q.size()), 64'd0);
        check("abort_outputs", 64'(outs()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports: i_req in 1 I-cache fill request (level); i_addr in 16 I-cache miss address.
REQ-004 SHALL have ports: d_req in 1 D-cache fill request (level); d_addr in 16 D-cache miss address.
REQ-005 SHALL have ports: d_wr_req in 1 D-cache write-through request (level); d_wr_addr in 16; d_wr_data in 16.
REQ-006 SHALL have ports: mem_en out 1 memory access strobe; mem_wr out 1 write qualifier; mem_addr out 16; mem_data_in out 16 write data.
REQ-007 SHALL have port: mem_data_valid  in  1  memory read word returned.
REQ-008 SHALL have ports: i_grant, d_grant out 1 (owner of memory); i_data_valid, d_data_valid out 1 (routed mem_data_valid).
REQ-009 SHALL have ports: fill_word out 3 index of current word; i_done, d_done out 1 one-cycle completion pulses; busy out 1 (state != IDLE).

Function
REQ-010 SHALL implement states IDLE, I_ISSUE, I_WAIT, D_ISSUE, D_WAIT, D_WRITE.
REQ-011 IDLE SHALL select, from requests sampled that cycle, fixed priority d_wr_req > d_req > i_req, entering D_WRITE / D_ISSUE / I_ISSUE next cycle; no request -> stay IDLE.
REQ-012 Fill block base SHALL be {addr[15:4], 4'h0}; word k address = base + {k, 1'b0}, k = 0..7, 16-bit wrap not required (base aligned).
REQ-013 x_ISSUE SHALL drive mem_en=1, mem_wr=0, mem_addr = word k address for exactly one cycle, then enter x_WAIT.
REQ-014 x_WAIT SHALL hold mem_en=0, keep mem_addr stable, stay until mem_data_valid=1.
REQ-015 In x_WAIT, x_data_valid SHALL equal mem_data_valid combinationally; fill_word SHALL equal k.
REQ-016 On valid in x_WAIT with k<7: k increments, next state x_ISSUE; with k=7: x_done pulses next cycle (IDLE), k clears to 0.
REQ-017 i_grant SHALL be 1 in I_ISSUE/I_WAIT; d_grant 1 in D_ISSUE/D_WAIT/D_WRITE; never both.
REQ-018 D_WRITE SHALL drive mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data for one cycle; d_done pulses the following cycle (IDLE).
REQ-019 mem_data_valid in IDLE, x_ISSUE or D_WRITE SHALL be ignored (no routing, no count).
REQ-020 A request deasserting mid-transaction SHALL NOT abort it; transaction completes and done pulses.
REQ-021 The cycle carrying x_done SHALL be IDLE and SHALL arbitrate; requester must drop request on sampling done, so a still-high request in that cycle is re-granted.
REQ-022 Total fill latency with memory valid every 4 cycles SHALL be 1 (grant) + 8x4 + 1 (done) cycles from request.
REQ-023 Outside grant, mem_addr and mem_data_in SHALL be 0; mem_data_in 0 except in D_WRITE.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, k=0, and all outputs 0 next cycle, including mid-fill or mid-write; no done pulse for an aborted transaction.
REQ-025 Requests during rst SHALL be ignored; arbitration resumes the first cycle after rst deasserts.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: between fills, requester not served last wins when i_req and d_req both high (last-served flag reset to I); d_wr_req still highest.
REQ-027 ARB_ROUND_ROBIN_EN undefined: fixed priority of REQ-011 only; no last-served state.

Verification
REQ-028 i_req=1, i_addr=16'hBEEF, valid every 4th cycle -> mem_addr 16'hBEE0,BEE2,...,BEEE; i_done pulse after 8th valid; d_grant stays 0.
REQ-029 d_wr_req=1, d_wr_addr=16'h1234, d_wr_data=16'hDEAD -> one cycle mem_en=1,mem_wr=1,addr 1234,data DEAD; d_done next cycle.
REQ-030 i_req, d_req, d_wr_req raised same cycle (addr 16'h0100/16'h2200/16'h3302) -> order write, D fill, I fill (fixed); with ARB_ROUND_ROBIN_EN, two back-to-back fills alternate D,I,D.
REQ-031 rst pulsed after 3rd valid of D fill at 16'hDEAD -> all outputs 0, no d_done; re-request refills from 16'hDEA0.
REQ-032 mem_data_valid pulsed while IDLE and during I_ISSUE -> no x_data_valid, fill_word unchanged.
